// File: rtl/project2_cpu_if.sv
// Instruction-fetch bus between the core and the external instruction memory.
// The core drives a byte-address PC and reads back the instruction in the same cycle.
interface project2_cpu_if;
  logic [31:0] pcOut;
  logic [31:0] instWord;

  modport master (output pcOut, input instWord);
  modport slave  (input pcOut, output instWord);
endinterface

// File: rtl/project2_cpu.sv
// Single-cycle 32-bit core: register file, data memory and memory-mapped board I/O
// (switches, keys, red/green LEDs, six 7-segment digits).
module project2_cpu #(
  parameter int          DBITS               = 32,
  parameter int          INST_SIZE           = 4,
  parameter logic [31:0] START_PC            = 32'h40,
  parameter int          REG_INDEX_BIT_WIDTH = 4,
  parameter int          DMEMWORDS           = 2048,
  parameter logic [31:0] ADDR_HEX            = 32'hF0000000,
  parameter logic [31:0] ADDR_LEDR           = 32'hF0000004,
  parameter logic [31:0] ADDR_LEDG           = 32'hF0000008,
  parameter logic [31:0] ADDR_KEY            = 32'hF0000010,
  parameter logic [31:0] ADDR_SW             = 32'hF0000014
) (
  input  logic                 CLOCK_50,
  input  logic                 FPGA_RESET_N,
  input  logic [9:0]           SW,
  input  logic [3:0]           KEY,
  output logic [9:0]           LEDR,
  output logic [6:0]           HEX0,
  output logic [6:0]           HEX1,
  output logic [6:0]           HEX2,
  output logic [6:0]           HEX3,
  output logic [6:0]           HEX4,
  output logic [6:0]           HEX5,
  project2_cpu_if.master       imem
);

  localparam int NREGS   = 1 << REG_INDEX_BIT_WIDTH;
  localparam int DMEM_AW = $clog2(DMEMWORDS);

  localparam logic [3:0] OP_ALUR  = 4'h0;
  localparam logic [3:0] OP_CMPR  = 4'h1;
  localparam logic [3:0] OP_ALUI  = 4'h2;
  localparam logic [3:0] OP_CMPI  = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BCOND = 4'h6;
  localparam logic [3:0] OP_JAL   = 4'hB;
  localparam logic [3:0] OP_BR    = 4'hC;

  // I/O registers are matched on word address, so the low two byte bits never matter
  localparam logic [29:0] W_HEX  = ADDR_HEX[31:2];
  localparam logic [29:0] W_LEDR = ADDR_LEDR[31:2];
  localparam logic [29:0] W_LEDG = ADDR_LEDG[31:2];
  localparam logic [29:0] W_KEY  = ADDR_KEY[31:2];
  localparam logic [29:0] W_SW   = ADDR_SW[31:2];

  function automatic logic [DBITS-1:0] alu_f(input logic [3:0] fn, input logic [DBITS-1:0] a,
                                             input logic [DBITS-1:0] b, input logic [15:0] imm);
    case (fn)
      4'h0:    alu_f = a + b;
      4'h1:    alu_f = a - b;
      4'h4:    alu_f = a & b;
      4'h5:    alu_f = a | b;
      4'h6:    alu_f = a ^ b;
      4'h8:    alu_f = ~(a & b);
      4'h9:    alu_f = ~(a | b);
      4'hA:    alu_f = ~(a ^ b);
      4'hF:    alu_f = {imm, 16'h0000};
      default: alu_f = 32'd0;
    endcase
  endfunction

  function automatic logic cmp_f(input logic [3:0] fn, input logic [DBITS-1:0] a,
                                 input logic [DBITS-1:0] b);
    logic eq, lt;
    eq = (a == b);
    lt = ($signed(a) < $signed(b));
    case (fn)
      4'h0:    cmp_f = 1'b0;
      4'h1:    cmp_f = eq;
      4'h2:    cmp_f = lt;
      4'h3:    cmp_f = lt | eq;
      4'h8:    cmp_f = 1'b1;
      4'h9:    cmp_f = ~eq;
      4'hA:    cmp_f = ~lt;
      4'hB:    cmp_f = ~(lt | eq);
      default: cmp_f = 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] seg7_f(input logic [3:0] nib);
    case (nib)
      4'h0: seg7_f = 7'b1000000;  4'h1: seg7_f = 7'b1111001;
      4'h2: seg7_f = 7'b0100100;  4'h3: seg7_f = 7'b0110000;
      4'h4: seg7_f = 7'b0011001;  4'h5: seg7_f = 7'b0010010;
      4'h6: seg7_f = 7'b0000010;  4'h7: seg7_f = 7'b1111000;
      4'h8: seg7_f = 7'b0000000;  4'h9: seg7_f = 7'b0010000;
      4'hA: seg7_f = 7'b0001000;  4'hB: seg7_f = 7'b0000011;
      4'hC: seg7_f = 7'b1000110;  4'hD: seg7_f = 7'b0100001;
      4'hE: seg7_f = 7'b0000110;  4'hF: seg7_f = 7'b0001110;
      default: seg7_f = 7'b1111111;
    endcase
  endfunction

  logic [DBITS-1:0]   pc_r;
  logic [DBITS-1:0]   regs_r [0:NREGS-1];
  logic [DBITS-1:0]   dmem_r [0:DMEMWORDS-1];
  logic [23:0]        hex_val_r;
  logic [9:0]         ledr_r;
  logic [7:0]         ledg_r;

  logic [3:0]         op_s, fn_s, rd_s, rs1_s, rs2_s;
  logic [15:0]        imm_s;
  logic [DBITS-1:0]   simm_s, rs1_val_s, rs2_val_s, rd_val_s;
  logic [DBITS-1:0]   pc_plus4_s, br_target_s, mem_addr_s;
  logic [DMEM_AW-1:0] dmem_idx_s;
  logic               is_io_s;
  logic [DBITS-1:0]   io_rdata_s, load_val_s;
  logic [DBITS-1:0]   pc_nxt_s, rf_wdata_s;
  logic               rf_we_s, st_en_s, dmem_we_s, hex_we_s, ledr_we_s, ledg_we_s;

  assign imem.pcOut = pc_r;
  assign LEDR       = ledr_r;

  // Field split, operand fetch and address generation
  always_comb begin
    op_s        = imem.instWord[31:28];
    fn_s        = imem.instWord[27:24];
    imm_s       = imem.instWord[23:8];
    rd_s        = imem.instWord[7:4];
    rs1_s       = imem.instWord[3:0];
    rs2_s       = imem.instWord[11:8];
    simm_s      = {{16{imm_s[15]}}, imm_s};
    rs1_val_s   = regs_r[rs1_s];
    rs2_val_s   = regs_r[rs2_s];
    rd_val_s    = regs_r[rd_s];
    pc_plus4_s  = pc_r + DBITS'(INST_SIZE);
    br_target_s = pc_plus4_s + {simm_s[DBITS-3:0], 2'b00};
    mem_addr_s  = rs1_val_s + simm_s;
    is_io_s     = (mem_addr_s >= ADDR_HEX);
    dmem_idx_s  = mem_addr_s[DMEM_AW+1:2];
  end

  // Load-data source: I/O register map or data memory
  always_comb begin
    case (mem_addr_s[31:2])
      W_HEX:   io_rdata_s = {8'd0, hex_val_r};
      W_LEDR:  io_rdata_s = {22'd0, ledr_r};
      W_LEDG:  io_rdata_s = {24'd0, ledg_r};
      W_KEY:   io_rdata_s = {28'd0, ~KEY};
      W_SW:    io_rdata_s = {22'd0, SW};
      default: io_rdata_s = 32'd0;
    endcase
    if (is_io_s) begin
      load_val_s = io_rdata_s;
    end else begin
      load_val_s = dmem_r[dmem_idx_s];
    end
  end

  // Per-opcode next PC, register write-back and store enables
  always_comb begin
    pc_nxt_s   = pc_plus4_s;
    rf_we_s    = 1'b0;
    rf_wdata_s = 32'd0;
    st_en_s    = 1'b0;
    case (op_s)
      OP_ALUR: begin rf_we_s = 1'b1; rf_wdata_s = alu_f(fn_s, rs1_val_s, rs2_val_s, imm_s); end
      OP_ALUI: begin rf_we_s = 1'b1; rf_wdata_s = alu_f(fn_s, rs1_val_s, simm_s, imm_s); end
      OP_CMPR: begin rf_we_s = 1'b1; rf_wdata_s = {31'd0, cmp_f(fn_s, rs1_val_s, rs2_val_s)}; end
      OP_CMPI: begin rf_we_s = 1'b1; rf_wdata_s = {31'd0, cmp_f(fn_s, rs1_val_s, simm_s)}; end
      OP_LW:   begin rf_we_s = 1'b1; rf_wdata_s = load_val_s; end
      OP_SW:   st_en_s = 1'b1;
      OP_BCOND: begin
        if (cmp_f(fn_s, rd_val_s, rs1_val_s)) begin
          pc_nxt_s = br_target_s;
        end else begin
          pc_nxt_s = pc_plus4_s;
        end
      end
      OP_JAL: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = pc_plus4_s;
        pc_nxt_s   = rs1_val_s + {simm_s[DBITS-3:0], 2'b00};
      end
      OP_BR:   pc_nxt_s = br_target_s;
      default: pc_nxt_s = pc_plus4_s;
    endcase
    dmem_we_s = st_en_s && !is_io_s;
    hex_we_s  = st_en_s && is_io_s && (mem_addr_s[31:2] == W_HEX);
    ledr_we_s = st_en_s && is_io_s && (mem_addr_s[31:2] == W_LEDR);
    ledg_we_s = st_en_s && is_io_s && (mem_addr_s[31:2] == W_LEDG);
  end

  // Architectural state: PC, register file and I/O output registers
  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      pc_r <= START_PC;
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {DBITS{1'b0}};
      hex_val_r <= 24'd0;
      ledr_r    <= 10'd0;
      ledg_r    <= 8'd0;
      HEX0 <= 7'b1000000; HEX1 <= 7'b1000000; HEX2 <= 7'b1000000;
      HEX3 <= 7'b1000000; HEX4 <= 7'b1000000; HEX5 <= 7'b1000000;
    end else begin
      pc_r <= pc_nxt_s;
      if (rf_we_s) regs_r[rd_s] <= rf_wdata_s;
      if (hex_we_s) begin
        hex_val_r <= rd_val_s[23:0];
        HEX0 <= seg7_f(rd_val_s[3:0]);   HEX1 <= seg7_f(rd_val_s[7:4]);
        HEX2 <= seg7_f(rd_val_s[11:8]);  HEX3 <= seg7_f(rd_val_s[15:12]);
        HEX4 <= seg7_f(rd_val_s[19:16]); HEX5 <= seg7_f(rd_val_s[23:20]);
      end
      if (ledr_we_s) ledr_r <= rd_val_s[9:0];
      if (ledg_we_s) ledg_r <= rd_val_s[7:0];
    end
  end

  // Data memory write port; contents survive reset but no store lands while reset is held
  always_ff @(posedge CLOCK_50) begin
    if (dmem_we_s && FPGA_RESET_N) dmem_r[dmem_idx_s] <= rd_val_s;
  end

endmodule

// File: tb/tb_project2_cpu.sv
// Directed bench for project2_cpu: small programs in a bench-side instruction memory,
// expected values queued on a scoreboard and popped against the DUT outputs.
module tb_project2_cpu;
  logic       CLOCK_50 = 1'b0;
  logic       FPGA_RESET_N;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  project2_cpu_if bus ();
  logic [31:0] imem [0:63];
  assign bus.instWord = imem[bus.pcOut[7:2]];

  project2_cpu dut (
    .CLOCK_50(CLOCK_50), .FPGA_RESET_N(FPGA_RESET_N), .SW(SW), .KEY(KEY), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .imem(bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          total = 0;
  int          bad   = 0;
  string       tag_q [$];
  logic [31:0] exp_q [$];

  task automatic sb_push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[7:2]] = w;
  endtask

  task automatic reset_dut();
    FPGA_RESET_N = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    FPGA_RESET_N = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_hex(input string t, input logic [6:0] h5, input logic [6:0] h4,
                           input logic [6:0] h3, input logic [6:0] h2, input logic [6:0] h1,
                           input logic [6:0] h0);
    sb_push({t, "_hex5"}, {25'd0, h5}); sb_check({25'd0, HEX5});
    sb_push({t, "_hex4"}, {25'd0, h4}); sb_check({25'd0, HEX4});
    sb_push({t, "_hex3"}, {25'd0, h3}); sb_check({25'd0, HEX3});
    sb_push({t, "_hex2"}, {25'd0, h2}); sb_check({25'd0, HEX2});
    sb_push({t, "_hex1"}, {25'd0, h1}); sb_check({25'd0, HEX1});
    sb_push({t, "_hex0"}, {25'd0, h0}); sb_check({25'd0, HEX0});
  endtask

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;

  initial begin
    FPGA_RESET_N = 1'b0;
    SW  = 10'd0;
    KEY = 4'hF;
    clear_prog();

    // reset state
    reset_dut();
    sb_push("rst_pc", 32'h40);   sb_check(bus.pcOut);
    sb_push("rst_ledr", 32'h0);  sb_check({22'd0, LEDR});
    check_hex("rst", S0, S0, S0, S0, S0, S0);

    // three-instruction loop: MVHI r0,0 / CMPI GT r0,r0,7 / BR -3
    clear_prog();
    put(32'h40, 32'h2f000000); put(32'h44, 32'h3b000700); put(32'h48, 32'hc0fffd00);
    reset_dut();
    for (int i = 0; i < 17; i++) sb_push("loop_pc", 32'h40 + 32'd4 * (i % 3));
    for (int i = 0; i < 17; i++) begin
      sb_check(bus.pcOut);
      step(1);
    end
    sb_push("loop_ledr", 32'h0); sb_check({22'd0, LEDR});

    // ADDI r2,0x3FF / MVHI r1,0xF000 / SW r2,4(r1) -> LEDR
    clear_prog();
    put(32'h40, 32'h2003ff20); put(32'h44, 32'h2ff00010); put(32'h48, 32'h50000421);
    put(32'h4c, 32'hc0ffff00);
    reset_dut();
    step(2);
    sb_push("ledr_before", 32'h0);   sb_check({22'd0, LEDR});
    step(1);
    sb_push("ledr_store", 32'h3ff);  sb_check({22'd0, LEDR});

    // HEX writes and read-back through LW
    clear_prog();
    put(32'h40, 32'h2ff00010); put(32'h44, 32'h20345620); put(32'h48, 32'h50000021);
    put(32'h4c, 32'h2fabcd30); put(32'h50, 32'h2501ef33); put(32'h54, 32'h50000031);
    put(32'h58, 32'h40000041); put(32'h5c, 32'h50000441); put(32'h60, 32'hc0ffff00);
    reset_dut();
    step(3);
    check_hex("hex3456", S0, S0, S3, S4, S5, S6);
    step(3);
    check_hex("hexcd01ef", SC, SD, S0, S1, SE, SF);
    step(2);
    sb_push("hex_readback", 32'h1ef); sb_check({22'd0, LEDR});

    // switch and key reads routed to LEDR
    SW  = 10'h2a5;
    KEY = 4'b1010;
    clear_prog();
    put(32'h40, 32'h2ff00010); put(32'h44, 32'h40001431); put(32'h48, 32'h50000431);
    put(32'h4c, 32'h40001051); put(32'h50, 32'h50000451); put(32'h54, 32'hc0ffff00);
    reset_dut();
    step(3);
    sb_push("sw_read", 32'h2a5);  sb_check({22'd0, LEDR});
    step(2);
    sb_push("key_read", 32'h005); sb_check({22'd0, LEDR});

    // data memory round trip, BEQ taken, BNE not taken, JAL
    clear_prog();
    put(32'h40, 32'h2fdeae20); put(32'h44, 32'h20beef22); put(32'h48, 32'h50010020);
    put(32'h4c, 32'h40010030); put(32'h50, 32'h61000232); put(32'h5c, 32'h69000232);
    put(32'h60, 32'h2ff00010); put(32'h64, 32'h50000431); put(32'h68, 32'hb0000460);
    put(32'h10, 32'h50000461); put(32'h14, 32'hc0ffff00);
    reset_dut();
    step(4);
    sb_push("pc_at_beq", 32'h50);     sb_check(bus.pcOut);
    step(1);
    sb_push("beq_taken", 32'h5c);     sb_check(bus.pcOut);
    step(1);
    sb_push("bne_fall", 32'h60);      sb_check(bus.pcOut);
    step(2);
    sb_push("dmem_load", 32'h2ef);    sb_check({22'd0, LEDR});
    sb_push("pc_at_jal", 32'h68);     sb_check(bus.pcOut);
    step(1);
    sb_push("jal_target", 32'h10);    sb_check(bus.pcOut);
    step(1);
    sb_push("jal_link", 32'h06c);     sb_check({22'd0, LEDR});
    step(1);
    sb_push("self_loop", 32'h14);     sb_check(bus.pcOut);

    // asynchronous reset takes effect without a clock edge
    #3;
    FPGA_RESET_N = 1'b0;
    #1;
    sb_push("async_rst_pc", 32'h40);  sb_check(bus.pcOut);
    sb_push("async_rst_ledr", 32'h0); sb_check({22'd0, LEDR});
    step(1);
    FPGA_RESET_N = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
